// File: rtl/commit_trace_checker_pkg.sv
// Shared types and constants for the commit trace checker: error codes,
// flag bit positions, the expected-record layout and the FSM encoding.
package commit_trace_checker_pkg;

    // Width of one expected commit record: flags + pc + reg + regval + addr + memval.
    localparam int REC_W = 70;

    // Cause of the first failure, reported on err_code.
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_PC        = 3'd1;
    localparam logic [2:0] ERR_FLAGS     = 3'd2;
    localparam logic [2:0] ERR_REG       = 3'd3;
    localparam logic [2:0] ERR_MEM       = 3'd4;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd5;

    // Bit positions inside the 3-bit {halt, mem_wr, reg_wr} flag field.
    localparam int FLG_REG  = 0;
    localparam int FLG_MEM  = 1;
    localparam int FLG_HALT = 2;

    // Checker FSM. PASS and FAIL are terminal until reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // One expected (or observed) commit. Field order fixes the FIFO word layout.
    typedef struct packed {
        logic [2:0]  flags;
        logic [15:0] pc;
        logic [2:0]  dst;
        logic [15:0] regval;
        logic [15:0] addr;
        logic [15:0] memval;
    } rec_t;

    // Assemble a record from its individual fields.
    function automatic rec_t make_rec(
        input logic [2:0]  flags,
        input logic [15:0] pc,
        input logic [2:0]  dst,
        input logic [15:0] regval,
        input logic [15:0] addr,
        input logic [15:0] memval
    );
        rec_t r;
        r.flags  = flags;
        r.pc     = pc;
        r.dst    = dst;
        r.regval = regval;
        r.addr   = addr;
        r.memval = memval;
        return r;
    endfunction

    // Compare an observed commit against an expected record.
    // Priority: pc, then flags, then register write data, then store data.
    // Register/store fields are only compared when the expected flag is set.
    function automatic logic [2:0] compare_rec(input rec_t exp_rec, input rec_t obs_rec);
        logic [2:0] code;
        code = ERR_NONE;
        if (obs_rec.pc != exp_rec.pc) begin
            code = ERR_PC;
        end else if (obs_rec.flags != exp_rec.flags) begin
            code = ERR_FLAGS;
        end else if (exp_rec.flags[FLG_REG] &&
                     (obs_rec.dst != exp_rec.dst || obs_rec.regval != exp_rec.regval)) begin
            code = ERR_REG;
        end else if (exp_rec.flags[FLG_MEM] &&
                     (obs_rec.addr != exp_rec.addr || obs_rec.memval != exp_rec.memval)) begin
            code = ERR_MEM;
        end
        return code;
    endfunction

endpackage

// File: rtl/commit_trace_checker_if.sv
// Load and commit buses of the commit trace checker.
//
// Load handshake: a record transfers on every rising clk edge where
// ld_valid && ld_ready are both high. The master holds the ld_* fields
// stable while ld_valid is high; ld_ready does not depend on ld_valid
// or on anything on the commit bus in the same cycle.
// Commit bus: c_valid marks a retirement in this cycle; there is no
// backpressure, the checker samples every c_valid it sees.
interface commit_trace_checker_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_flags;
    logic [15:0] ld_pc;
    logic [2:0]  ld_reg;
    logic [15:0] ld_regval;
    logic [15:0] ld_addr;
    logic [15:0] ld_memval;

    logic        c_valid;
    logic [15:0] c_pc;
    logic [2:0]  c_flags;
    logic [2:0]  c_reg;
    logic [15:0] c_regval;
    logic [15:0] c_addr;
    logic [15:0] c_memval;

    // Record source and processor tap side.
    modport master (
        output ld_valid, ld_flags, ld_pc, ld_reg, ld_regval, ld_addr, ld_memval,
        output c_valid, c_pc, c_flags, c_reg, c_regval, c_addr, c_memval,
        input  ld_ready
    );

    // Checker side.
    modport slave (
        input  ld_valid, ld_flags, ld_pc, ld_reg, ld_regval, ld_addr, ld_memval,
        input  c_valid, c_pc, c_flags, c_reg, c_regval, c_addr, c_memval,
        output ld_ready
    );

endinterface

// File: rtl/commit_trace_checker_trace_fifo.sv
// Synchronous FIFO holding expected commit records. Full/empty are
// derived from a registered occupancy count, so they never reflect a
// push or pop happening in the same cycle.
module trace_fifo
    import commit_trace_checker_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REC_W-1:0] din,
    input  logic             pop,
    output logic [REC_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + COUNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Commit trace checker: buffers expected commit records and checks every
// live retirement against the oldest one. Reports pass on a matched halt
// record, or fail with the cause and instruction number of the first
// mismatch. pass/fail/err_code/err_inum are sticky until rst.
module commit_trace_checker
    import commit_trace_checker_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    commit_trace_checker_if.slave        bus,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic [2:0]                   err_code,
    output logic [15:0]                  inst_count,
    output logic [15:0]                  err_inum,
    output state_t                       dbg_state
);

    state_t           state;
    rec_t             ld_rec;
    rec_t             head_rec;
    rec_t             obs_rec;
    logic [REC_W-1:0] head_bits;
    logic             full;
    logic             empty;
    logic             push;
    logic             check;
    logic             pop;
    logic [2:0]       cmp_code;

    assign ld_rec = make_rec(bus.ld_flags, bus.ld_pc, bus.ld_reg,
                             bus.ld_regval, bus.ld_addr, bus.ld_memval);
    assign obs_rec = make_rec(bus.c_flags, bus.c_pc, bus.c_reg,
                              bus.c_regval, bus.c_addr, bus.c_memval);
    assign head_rec = rec_t'(head_bits);

    // Loads are accepted only while the checker can still use them; both
    // terms are registered so ld_ready ignores any same-cycle pop.
    assign bus.ld_ready = !full && (state == ST_IDLE || state == ST_RUN);
    assign push         = bus.ld_valid && bus.ld_ready;

    // A retirement is only examined in RUN; an empty FIFO is an underflow
    // (no bypass from a push arriving in the same cycle).
    assign check = (state == ST_RUN) && bus.c_valid;
    assign pop   = check && !empty;

    assign busy      = (state == ST_RUN);
    assign dbg_state = state;

    trace_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ld_rec),
        .pop   (pop),
        .head  (head_bits),
        .full  (full),
        .empty (empty)
    );

    // Prioritised comparison of the retiring instruction against the FIFO head.
    always_comb begin
        cmp_code = compare_rec(head_rec, obs_rec);
    end

    // Checker FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= ERR_NONE;
            inst_count <= '0;
            err_inum   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (check) begin
                        if (empty) begin
                            state    <= ST_FAIL;
                            fail     <= 1'b1;
                            err_code <= ERR_UNDERFLOW;
                            err_inum <= inst_count;
                        end else if (cmp_code != ERR_NONE) begin
                            state    <= ST_FAIL;
                            fail     <= 1'b1;
                            err_code <= cmp_code;
                            err_inum <= inst_count;
                        end else begin
                            inst_count <= inst_count + 16'd1;
                            if (head_rec.flags[FLG_HALT]) begin
                                state <= ST_PASS;
                                pass  <= 1'b1;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    state <= ST_PASS;
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: a queue-based reference model
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_commit_trace_checker;
    import commit_trace_checker_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [2:0]  err_code;
    logic [15:0] inst_count;
    logic [15:0] err_inum;
    state_t      dbg_state;

    commit_trace_checker_if bus ();

    commit_trace_checker #(.DEPTH(16), .PTR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code),
        .inst_count (inst_count),
        .err_inum   (err_inum),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Expected records waiting to be matched, plus the run outcome.
    rec_t        exp_q[$];
    bit          m_started;
    bit          m_pass;
    bit          m_fail;
    logic [2:0]  m_code;
    logic [15:0] m_count;
    logic [15:0] m_inum;
    bit          chk_en = 1'b0;

    function automatic bit m_running();
        return m_started && !m_pass && !m_fail;
    endfunction

    function automatic bit m_ready();
        return (exp_q.size() < DEPTH) && !m_pass && !m_fail;
    endfunction

    function automatic state_t m_state();
        if (!m_started) return ST_IDLE;
        if (m_pass) return ST_PASS;
        if (m_fail) return ST_FAIL;
        return ST_RUN;
    endfunction

    always @(posedge clk) begin : model
        bit         ready_now;
        bit         run_now;
        rec_t       e;
        rec_t       c;
        logic [2:0] code;
        if (rst) begin
            exp_q.delete();
            m_started = 0; m_pass = 0; m_fail = 0;
            m_code = 3'd0; m_count = 16'd0; m_inum = 16'd0;
            chk_en = 1'b1;
        end else begin
            ready_now = m_ready();
            run_now   = m_running();
            if (run_now && bus.c_valid) begin
                if (exp_q.size() == 0) begin
                    m_fail = 1; m_code = 3'd5; m_inum = m_count;
                end else begin
                    e = exp_q.pop_front();
                    c = make_rec(bus.c_flags, bus.c_pc, bus.c_reg, bus.c_regval, bus.c_addr, bus.c_memval);
                    if (c.pc != e.pc) code = 3'd1;
                    else if (c.flags != e.flags) code = 3'd2;
                    else if (e.flags[0] && (c.dst != e.dst || c.regval != e.regval)) code = 3'd3;
                    else if (e.flags[1] && (c.addr != e.addr || c.memval != e.memval)) code = 3'd4;
                    else code = 3'd0;
                    if (code != 3'd0) begin
                        m_fail = 1; m_code = code; m_inum = m_count;
                    end else begin
                        m_count = m_count + 16'd1;
                        if (e.flags[2]) m_pass = 1;
                    end
                end
            end
            if (bus.ld_valid && ready_now)
                exp_q.push_back(make_rec(bus.ld_flags, bus.ld_pc, bus.ld_reg, bus.ld_regval, bus.ld_addr, bus.ld_memval));
            if (!m_started && start) m_started = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       32'(busy),         32'(m_running()));
            chk("ld_ready",   32'(bus.ld_ready), 32'(m_ready()));
            chk("pass",       32'(pass),         32'(m_pass));
            chk("fail",       32'(fail),         32'(m_fail));
            chk("err_code",   32'(err_code),     32'(m_code));
            chk("inst_count", 32'(inst_count),   32'(m_count));
            chk("err_inum",   32'(err_inum),     32'(m_inum));
            chk("state",      32'(dbg_state),    32'(m_state()));
        end
    end

    // ---------------- driver tasks ----------------
    // Each task is entered just after a falling edge and returns on one.
    task automatic idle_bus();
        bus.ld_valid = 0; bus.ld_flags = 0; bus.ld_pc = 0; bus.ld_reg = 0;
        bus.ld_regval = 0; bus.ld_addr = 0; bus.ld_memval = 0;
        bus.c_valid = 0; bus.c_flags = 0; bus.c_pc = 0; bus.c_reg = 0;
        bus.c_regval = 0; bus.c_addr = 0; bus.c_memval = 0;
        start = 0;
    endtask

    task automatic set_ld(input rec_t r);
        bus.ld_valid = 1; bus.ld_flags = r.flags; bus.ld_pc = r.pc; bus.ld_reg = r.dst;
        bus.ld_regval = r.regval; bus.ld_addr = r.addr; bus.ld_memval = r.memval;
    endtask

    task automatic set_c(input rec_t r);
        bus.c_valid = 1; bus.c_flags = r.flags; bus.c_pc = r.pc; bus.c_reg = r.dst;
        bus.c_regval = r.regval; bus.c_addr = r.addr; bus.c_memval = r.memval;
    endtask

    task automatic load(input rec_t r);
        set_ld(r); @(negedge clk); idle_bus();
    endtask

    task automatic commit(input rec_t r);
        set_c(r); @(negedge clk); idle_bus();
    endtask

    task automatic load_and_commit(input rec_t l, input rec_t c);
        set_ld(l); set_c(c); @(negedge clk); idle_bus();
    endtask

    task automatic pulse_start();
        start = 1; @(negedge clk); idle_bus();
    endtask

    task automatic do_reset();
        rst = 1; @(negedge clk); rst = 0;
    endtask

    // ---------------- stimulus ----------------
    rec_t ra, rb, rc, rd;

    initial begin
        rst = 1;
        idle_bus();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("lit_rst_ready", 32'(bus.ld_ready), 32'd1);
        chk("lit_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // All-match run
        ra = make_rec(3'b001, 16'h0000, 3'd1, 16'h0005, 16'h0000, 16'h0000);
        rb = make_rec(3'b000, 16'h0002, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        rc = make_rec(3'b010, 16'h0004, 3'd0, 16'h0000, 16'h0010, 16'h0005);
        rd = make_rec(3'b100, 16'h0006, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        load(ra); load(rb); load(rc); load(rd);
        pulse_start();
        chk("lit_run_busy", 32'(busy), 32'd1);
        commit(ra); commit(rb); commit(rc);
        chk("lit_pre_halt_pass", 32'(pass), 32'd0);
        commit(rd);
        chk("lit_match_count", 32'(inst_count), 32'd4);
        chk("lit_match_pass", 32'(pass), 32'd1);
        chk("lit_match_fail", 32'(fail), 32'd0);
        @(negedge clk);

        // Data mismatch on the second commit
        do_reset();
        rb = make_rec(3'b001, 16'h0002, 3'd2, 16'h0005, 16'h0000, 16'h0000);
        load(ra); load(rb); load(rc); load(rd);
        pulse_start();
        commit(ra);
        commit(make_rec(3'b001, 16'h0002, 3'd2, 16'h0007, 16'h0000, 16'h0000));
        chk("lit_data_fail", 32'(fail), 32'd1);
        chk("lit_data_code", 32'(err_code), 32'd3);
        chk("lit_data_inum", 32'(err_inum), 32'd1);
        commit(rc); commit(rd);
        chk("lit_data_sticky_code", 32'(err_code), 32'd3);
        chk("lit_data_sticky_count", 32'(inst_count), 32'd1);
        chk("lit_data_sticky_pass", 32'(pass), 32'd0);

        // Underflow with a same-cycle push
        do_reset();
        pulse_start();
        load_and_commit(ra, ra);
        chk("lit_uflow_fail", 32'(fail), 32'd1);
        chk("lit_uflow_code", 32'(err_code), 32'd5);
        chk("lit_uflow_inum", 32'(err_inum), 32'd0);

        // Full FIFO / backpressure
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            load(make_rec(3'b000, 16'(2 * i), 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_full_ready", 32'(bus.ld_ready), 32'd0);
        load(make_rec(3'b000, 16'h0100, 3'd0, 16'h0, 16'h0, 16'h0));
        pulse_start();
        // Pop while full: the same-cycle push must still be refused.
        load_and_commit(make_rec(3'b000, 16'h0200, 3'd0, 16'h0, 16'h0, 16'h0),
                        make_rec(3'b000, 16'h0000, 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_after_pop_ready", 32'(bus.ld_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++)
            commit(make_rec(3'b000, 16'(2 * i), 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_full_count", 32'(inst_count), 32'd16);
        commit(make_rec(3'b000, 16'h0100, 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_full_17th_dropped", 32'(err_code), 32'd5);
        chk("lit_full_inum", 32'(err_inum), 32'd16);

        // Priority: pc and flags both wrong
        do_reset();
        load(make_rec(3'b001, 16'h0010, 3'd1, 16'h0005, 16'h0, 16'h0));
        pulse_start();
        commit(make_rec(3'b010, 16'h0012, 3'd1, 16'h0005, 16'h0, 16'h0));
        chk("lit_prio_code", 32'(err_code), 32'd1);

        // Don't-care fields, simultaneous push/pop in RUN
        do_reset();
        load(make_rec(3'b000, 16'h0020, 3'd0, 16'h0000, 16'h0000, 16'h0000));
        pulse_start();
        load_and_commit(make_rec(3'b100, 16'h0022, 3'd0, 16'h0, 16'h0, 16'h0),
                        make_rec(3'b000, 16'h0020, 3'd5, 16'h1234, 16'hbeef, 16'h5678));
        chk("lit_dc_count", 32'(inst_count), 32'd1);
        chk("lit_dc_fail", 32'(fail), 32'd0);
        commit(make_rec(3'b100, 16'h0022, 3'd7, 16'hffff, 16'h0, 16'h0));
        chk("lit_dc_pass", 32'(pass), 32'd1);
        chk("lit_dc_count2", 32'(inst_count), 32'd2);

        // Reset mid-run with records queued
        do_reset();
        for (int i = 0; i < 5; i++)
            load(make_rec(3'b000, 16'(16'h0040 + 2 * i), 3'd0, 16'h0, 16'h0, 16'h0));
        pulse_start();
        commit(make_rec(3'b000, 16'h0040, 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_mid_count", 32'(inst_count), 32'd1);
        do_reset();
        chk("lit_mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("lit_mid_rst_count", 32'(inst_count), 32'd0);
        chk("lit_mid_rst_ready", 32'(bus.ld_ready), 32'd1);
        chk("lit_mid_rst_busy", 32'(busy), 32'd0);
        pulse_start();
        commit(make_rec(3'b000, 16'h0042, 3'd0, 16'h0, 16'h0, 16'h0));
        chk("lit_mid_empty_code", 32'(err_code), 32'd5);
        chk("lit_mid_empty_inum", 32'(err_inum), 32'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
